// File: rtl/autoencoder_sequencer_pkg.sv
// Shared definitions for the autoencoder sequencer: opcodes, demux destinations,
// FSM state encodings and the small decode helpers used by the control path.
package autoencoder_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_ADD      = 4'h1,
        OP_MUL      = 4'h2,
        OP_ADD_RELU = 4'h3,
        OP_ADD_SIG  = 4'h4,
        OP_MUL_SIGD = 4'h5,
        OP_SETLOOP  = 4'hC,
        OP_LOOP     = 4'hD,
        OP_JUMP     = 4'hE,
        OP_HALT     = 4'hF
    } opcode_e;

    localparam logic [1:0] DEST_MEM  = 2'b00;
    localparam logic [1:0] DEST_SIG  = 2'b01;
    localparam logic [1:0] DEST_RELU = 2'b10;
    localparam logic [1:0] DEST_SIGD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_e;

    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL_SIGD);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'h6) && (op <= 4'hB);
    endfunction

    function automatic logic [1:0] dest_of(input logic [3:0] op);
        case (op)
            OP_ADD_RELU: return DEST_RELU;
            OP_ADD_SIG:  return DEST_SIG;
            OP_MUL_SIGD: return DEST_SIGD;
            default:     return DEST_MEM;
        endcase
    endfunction

    function automatic logic op_sel_of(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MUL_SIGD);
    endfunction

endpackage

// File: rtl/autoencoder_sequencer_seq_pc_unit.sv
// Program counter for the sequencer: clear on start, load on jump/loop, or increment.
// Increment wraps modulo 2^ADDR_W with no flag.
module seq_pc_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   pc <= '0;
        else if (clear) pc <= '0;
        else if (load)  pc <= target;
        else if (inc)   pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/autoencoder_sequencer.sv
// Multi-cycle instruction sequencer: fetches, decodes and steps the autoencoder
// datapath through select / ALU / demux / write phases, with HALT, JUMP and one loop counter.
module autoencoder_sequencer
    import autoencoder_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16,
    parameter int LOOP_W  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output logic               illegal_op,
    output logic               enable_sel_mem,
    output logic               enable_ALU,
    output logic               op_select,
    output logic [1:0]         dest_control,
    output logic               write_enable_mem
);

    state_e             state, state_d;
    logic [INSTR_W-1:0] ir, ir_d;
    logic [LOOP_W-1:0]  loop_cnt, loop_d;
    logic               illegal_d;
    logic               pc_clear, pc_load, pc_inc;
    logic [3:0]         op_in, ir_op_d;
    logic               alu_phase_d;

    // Only the opcode of the latched instruction drives outputs here; the
    // operand fields feed the datapath's own sector-select registers.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[INSTR_W-5:0];

    assign op_in = instruction[INSTR_W-1 -: 4];

    seq_pc_unit #(.ADDR_W(ADDR_W)) u_pc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (pc_clear),
        .load    (pc_load),
        .inc     (pc_inc),
        .target  (instruction[ADDR_W-1:0]),
        .pc      (pc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ir         <= '0;
            loop_cnt   <= '0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_d;
            ir         <= ir_d;
            loop_cnt   <= loop_d;
            illegal_op <= illegal_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        ir_d      = ir;
        loop_d    = loop_cnt;
        illegal_d = illegal_op;
        pc_clear  = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_clear  = 1'b1;
                    illegal_d = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = instruction;
                if (is_arith(op_in)) begin
                    state_d = ST_READ;
                end else if (op_in == OP_HALT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                    case (op_in)
                        OP_SETLOOP: begin
                            loop_d = instruction[LOOP_W-1:0];
                            pc_inc = 1'b1;
                        end
                        OP_LOOP: begin
                            // Branch back only while the decremented count is still non-zero.
                            if (loop_cnt != '0) begin
                                loop_d = loop_cnt - LOOP_W'(1);
                                if (loop_cnt != LOOP_W'(1)) pc_load = 1'b1;
                                else                        pc_inc  = 1'b1;
                            end else begin
                                pc_inc = 1'b1;
                            end
                        end
                        OP_JUMP: pc_load = 1'b1;
                        default: begin
                            if (is_illegal(op_in)) illegal_d = 1'b1;
                            pc_inc = 1'b1;
                        end
                    endcase
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                state_d = ST_FETCH;
                pc_inc  = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    assign ir_op_d     = ir_d[INSTR_W-1 -: 4];
    assign alu_phase_d = (state_d == ST_EXEC) || (state_d == ST_WRITE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            enable_sel_mem   <= 1'b0;
            enable_ALU       <= 1'b0;
            op_select        <= 1'b0;
            dest_control     <= DEST_MEM;
            write_enable_mem <= 1'b0;
        end else begin
            busy             <= (state_d != ST_IDLE);
            done             <= (state_d == ST_DONE);
            enable_sel_mem   <= (state_d == ST_READ);
            enable_ALU       <= alu_phase_d;
            op_select        <= alu_phase_d ? op_sel_of(ir_op_d) : 1'b0;
            dest_control     <= alu_phase_d ? dest_of(ir_op_d) : DEST_MEM;
            write_enable_mem <= (state_d == ST_WRITE);
        end
    end

endmodule
